data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the CPU data port (MEM_addr/MEM_WR_out/MEM_type/MEM_rd_en/MEM_wr_en -> MEM_data).
//   Provides a word-organised, byte-addressable data RAM.
//   Supports sized, sign/zero-extended loads and byte-lane stores.
//   Registered read response; sticky misalignment detection.
//   Sits between CPU_TopLevel and the bench/SoC in place of the behavioural data memory.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words; power of two
//   AW           10    word-index width = log2(DEPTH_WORDS)
// PORTS
//   CLK            in   1   rising-edge clock
//   Reset_n        in   1   asynchronous active-low reset
//   address        in   32  byte address from CPU (MEM_addr)
//   write_enable   in   1   store request this cycle
//   read_enable    in   1   load request this cycle
//   write_data     in   32  store data, right-justified (MEM_WR_out)
//   xfer_size      in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   read_data      out  32  load result, extended per xfer_size
//   read_valid     out  1   read_data updated this cycle (1 cycle after read_enable)
//   misalign_err   out  1   sticky: any misaligned or illegal-size access since reset
//   err_count      out  8   saturating count of rejected accesses
// BEHAVIOUR
//   - Reset (async assert, sync release): read_data=0, read_valid=0, misalign_err=0, err_count=0.
//     RAM contents are NOT cleared.
//   - Word index = address[AW+1:2]; upper address bits ignored (aliasing, modulo DEPTH_WORDS*4 bytes).
//   - Alignment: H/HU need address[0]=0; W needs address[1:0]=00; B/BU are always aligned.
//     xfer_size 011, 110, 111 are illegal.
//     Stores accept only 000/001/010; 100/101 on a store are illegal.
//   - Store (write_enable=1, legal, aligned): at posedge CLK write byte lanes.
//     B: lane address[1:0] <= write_data[7:0].
//     H: lanes {a+1,a} <= write_data[15:0].
//     W: all lanes <= write_data.
//     Other lanes are unchanged.
//   - Load (read_enable=1): sampled at posedge N; read_data/read_valid update at posedge N.
//     They are visible during cycle N+1 (1-cycle latency).
//     read_valid is a single-cycle pulse per request; back-to-back loads give back-to-back valid.
//     B/H: selected lane(s) sign-extended; BU/HU zero-extended; W returned as is.
//   - read_data holds its last value when no load is issued.
//   - Simultaneous write_enable & read_enable: the store is performed first (write-first).
//     The load returns post-store contents of the addressed word.
//   - Rejected access (misaligned or illegal size): RAM is not written.
//     A rejected load still pulses read_valid, with read_data=0.
//     misalign_err is set and err_count increments, saturating at 8'hFF.
//     A cycle with both enables and a rejection counts once.
//   - Reset asserted mid-operation: a pending read_valid is dropped immediately (no response after release).
//     A store on the same edge as reset release is ignored.
//   - No back-pressure: every request completes; CPU never stalls on this block.
// TESTING
//   1. SW 0xDEADBEEF @0x10; LW @0x10 -> read_valid one cycle later, read_data=0xDEADBEEF.
//   2. SB 0x80 @0x13 over 0x00000000; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
//   3. SH 0x1234 @0x22; LH @0x22 -> 0x00001234; LHU @0x20 -> lower half unchanged; SW/LW @0x21 -> rejected:
//      read_data=0, misalign_err=1, err_count=2, RAM word 0x20 unchanged.
//   4. Same cycle: SW 0xA5A5A5A5 + LW @0x40 -> read_data=0xA5A5A5A5 next cycle.
//      Alias check: LW @(0x40+DEPTH_WORDS*4) -> same value.
//   5. 300 misaligned accesses -> err_count saturates at 0xFF; Reset_n low mid-load -> read_valid=0 with no response after release;
//      outputs zeroed, RAM data retained.
//   6. Full CPU_TopLevel program run of 330 cycles with this block replacing Memory -> identical store trace and final RAM image.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressable word RAM with sized loads/stores and sticky misalignment tracking
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [31:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] write_data,
  input  logic [2:0]  xfer_size,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        misalign_err,
  output logic [7:0]  err_count
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, misalign_q, misalign_d, run_q;
  logic [7:0]  err_count_q, err_count_d;
  logic [AW-1:0] idx;
  logic [1:0]  ofs;
  logic        sz_h, sz_w, ld_legal, st_legal, aligned, ld_rej, st_rej, st_ok;
  logic [3:0]  be;
  logic [31:0] wlane, cur, merged, word, sh, ext;
  logic        unused_addr;

  assign unused_addr = ^address[31:AW+2];
  assign idx = address[AW+1:2];
  assign ofs = address[1:0];
  assign cur = mem_q[idx];

  // Decode the access, merge store lanes and form the write-first load result
  always_comb begin
    sz_h = xfer_size[1:0] == 2'b01;
    sz_w = xfer_size[1:0] == 2'b10;
    ld_legal = !(xfer_size == 3'b011 || xfer_size[2:1] == 2'b11);
    st_legal = !xfer_size[2] && xfer_size[1:0] != 2'b11;
    aligned = sz_w ? ofs == 2'b00 : sz_h ? !ofs[0] : 1'b1;
    ld_rej = read_enable && !(ld_legal && aligned);
    st_rej = write_enable && !(st_legal && aligned);
    st_ok = write_enable && st_legal && aligned && run_q;
    be = sz_w ? 4'hF : sz_h ? 4'b0011 << ofs : 4'b0001 << ofs;
    wlane = sz_w ? write_data : sz_h ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wlane[8*i +: 8] : cur[8*i +: 8];
    word = st_ok ? merged : cur;
    sh = word >> {ofs, 3'b000};
    ext = sz_w ? word : sz_h ? {{16{sh[15] & ~xfer_size[2]}}, sh[15:0]} : {{24{sh[7] & ~xfer_size[2]}}, sh[7:0]};
    read_data_d = read_enable ? (ld_rej ? 32'h0 : ext) : read_data_q;
    misalign_d = misalign_q || ld_rej || st_rej;
    err_count_d = ((ld_rej || st_rej) && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  // Response and error state; run_q keeps the reset-release edge from writing
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      read_data_q <= '0;
      read_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      err_count_q <= '0;
      run_q <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      read_valid_q <= read_enable;
      misalign_q <= misalign_d;
      err_count_q <= err_count_d;
      run_q <= 1'b1;
    end
  end

  // RAM storage is never cleared by reset
  always_ff @(posedge CLK) begin
    if (st_ok) mem_q[idx] <= merged;
  end

  assign read_data = read_data_q;
  assign read_valid = read_valid_q;
  assign misalign_err = misalign_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector table plus reset/saturation sequences
module tb_data_mem_responder;
  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] address = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] write_data = '0;
  logic [2:0]  xfer_size = '0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misalign_err;
  logic [7:0]  err_count;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  sz;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    logic [7:0]  ec;
  } vec_t;

  vec_t v [28];

  data_mem_responder dut (
    .CLK(CLK), .Reset_n(Reset_n), .address(address), .write_enable(write_enable),
    .read_enable(read_enable), .write_data(write_data), .xfer_size(xfer_size),
    .read_data(read_data), .read_valid(read_valid), .misalign_err(misalign_err),
    .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz);
    write_enable = we;
    read_enable = re;
    address = a;
    write_data = wd;
    xfer_size = sz;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    v[0]  = '{1, 0, 32'h10,   32'hDEADBEEF, 3'd2, 0, 32'h0,        0, 8'd0};
    v[1]  = '{0, 1, 32'h10,   32'h0,        3'd2, 1, 32'hDEADBEEF, 0, 8'd0};
    v[2]  = '{1, 0, 32'h10,   32'h0,        3'd2, 0, 32'hDEADBEEF, 0, 8'd0};
    v[3]  = '{1, 0, 32'h13,   32'h12345680, 3'd0, 0, 32'hDEADBEEF, 0, 8'd0};
    v[4]  = '{0, 1, 32'h13,   32'h0,        3'd0, 1, 32'hFFFFFF80, 0, 8'd0};
    v[5]  = '{0, 1, 32'h13,   32'h0,        3'd4, 1, 32'h00000080, 0, 8'd0};
    v[6]  = '{0, 1, 32'h10,   32'h0,        3'd2, 1, 32'h80000000, 0, 8'd0};
    v[7]  = '{1, 0, 32'h20,   32'h5678ABCD, 3'd2, 0, 32'h80000000, 0, 8'd0};
    v[8]  = '{1, 0, 32'h22,   32'hFFFF1234, 3'd1, 0, 32'h80000000, 0, 8'd0};
    v[9]  = '{0, 1, 32'h22,   32'h0,        3'd1, 1, 32'h00001234, 0, 8'd0};
    v[10] = '{0, 1, 32'h20,   32'h0,        3'd5, 1, 32'h0000ABCD, 0, 8'd0};
    v[11] = '{0, 1, 32'h20,   32'h0,        3'd2, 1, 32'h1234ABCD, 0, 8'd0};
    v[12] = '{1, 0, 32'h21,   32'h0,        3'd2, 0, 32'h1234ABCD, 1, 8'd1};
    v[13] = '{0, 1, 32'h21,   32'h0,        3'd2, 1, 32'h0,        1, 8'd2};
    v[14] = '{0, 1, 32'h20,   32'h0,        3'd2, 1, 32'h1234ABCD, 1, 8'd2};
    v[15] = '{1, 1, 32'h40,   32'hA5A5A5A5, 3'd2, 1, 32'hA5A5A5A5, 1, 8'd2};
    v[16] = '{0, 1, 32'h1040, 32'h0,        3'd2, 1, 32'hA5A5A5A5, 1, 8'd2};
    v[17] = '{0, 1, 32'h42,   32'h0,        3'd1, 1, 32'hFFFFA5A5, 1, 8'd2};
    v[18] = '{0, 1, 32'h43,   32'h0,        3'd4, 1, 32'h000000A5, 1, 8'd2};
    v[19] = '{0, 1, 32'h40,   32'h0,        3'd3, 1, 32'h0,        1, 8'd3};
    v[20] = '{1, 0, 32'h40,   32'h0,        3'd4, 0, 32'h0,        1, 8'd4};
    v[21] = '{0, 1, 32'h40,   32'h0,        3'd2, 1, 32'hA5A5A5A5, 1, 8'd4};
    v[22] = '{1, 1, 32'h42,   32'h0,        3'd2, 1, 32'h0,        1, 8'd5};
    v[23] = '{0, 0, 32'h40,   32'h0,        3'd2, 0, 32'h0,        1, 8'd5};
    v[24] = '{0, 1, 32'h10,   32'h0,        3'd2, 1, 32'h80000000, 1, 8'd5};
    v[25] = '{1, 1, 32'h12,   32'h0000007F, 3'd0, 1, 32'h0000007F, 1, 8'd5};
    v[26] = '{0, 1, 32'h10,   32'h0,        3'd2, 1, 32'h807F0000, 1, 8'd5};
    v[27] = '{0, 1, 32'h40,   32'h0,        3'd6, 1, 32'h0,        1, 8'd6};

    tick();
    chk("rst.valid", {31'h0, read_valid}, 32'h0);
    chk("rst.data", read_data, 32'h0);
    chk("rst.err", {31'h0, misalign_err}, 32'h0);
    chk("rst.cnt", {24'h0, err_count}, 32'h0);
    #3 Reset_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 28; i++) begin
      drive(v[i].we, v[i].re, v[i].addr, v[i].wd, v[i].sz);
      tick();
      chk($sformatf("v%0d.valid", i), {31'h0, read_valid}, {31'h0, v[i].ev});
      chk($sformatf("v%0d.data", i), read_data, v[i].ed);
      chk($sformatf("v%0d.err", i), {31'h0, misalign_err}, {31'h0, v[i].ee});
      chk($sformatf("v%0d.cnt", i), {24'h0, err_count}, {24'h0, v[i].ec});
    end

    drive(1, 0, 32'h01, 32'h0, 3'd2);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 247) chk("sat.cnt254", {24'h0, err_count}, 32'hFE);
    end
    chk("sat.cnt", {24'h0, err_count}, 32'hFF);
    chk("sat.err", {31'h0, misalign_err}, 32'h1);

    drive(0, 1, 32'h40, 32'h0, 3'd2);
    tick();
    chk("mid.valid", {31'h0, read_valid}, 32'h1);
    chk("mid.data", read_data, 32'hA5A5A5A5);
    Reset_n = 1'b0;
    drive(1, 0, 32'h40, 32'hFFFFFFFF, 3'd2);
    #1;
    chk("arst.valid", {31'h0, read_valid}, 32'h0);
    chk("arst.data", read_data, 32'h0);
    chk("arst.err", {31'h0, misalign_err}, 32'h0);
    chk("arst.cnt", {24'h0, err_count}, 32'h0);
    @(negedge CLK);
    Reset_n = 1'b1;
    tick();
    drive(0, 0, 32'h40, 32'h0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post.valid%0d", i), {31'h0, read_valid}, 32'h0);
      tick();
    end
    drive(0, 1, 32'h40, 32'h0, 3'd2);
    tick();
    chk("keep.valid", {31'h0, read_valid}, 32'h1);
    chk("keep.data", read_data, 32'hA5A5A5A5);
    drive(0, 0, 32'h0, 32'h0, 3'd2);
    tick();
    chk("keep.pulse", {31'h0, read_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
